// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO drain slice: default word width and a
// counter-width helper used to size the beat and idle counters.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    if (max_val < 32'sd2) begin
      return 32'sd1;
    end else begin
      return $clog2(max_val + 32'sd1);
    end
  endfunction

endpackage

// File: rtl/drain_skid_buf.sv
// Two-entry holding buffer between the FIFO read port and the burst output.
// Pushes land in the first free entry; a simultaneous push and pop shifts.
module drain_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] head_r;
  logic [DATA_WIDTH-1:0] tail_r;
  logic [1:0]            occ_r;

  // Entry storage and occupancy; callers never push into a full buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r <= {DATA_WIDTH{1'b0}};
      tail_r <= {DATA_WIDTH{1'b0}};
      occ_r  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_r == 2'd0) begin
            head_r <= push_data;
            occ_r  <= 2'd1;
          end else begin
            tail_r <= push_data;
            occ_r  <= 2'd2;
          end
        end
        2'b01: begin
          head_r <= tail_r;
          tail_r <= {DATA_WIDTH{1'b0}};
          occ_r  <= occ_r - 2'd1;
        end
        2'b11: begin
          if (occ_r == 2'd1) begin
            head_r <= push_data;
          end else begin
            head_r <= tail_r;
            tail_r <= push_data;
          end
        end
        default: begin
          occ_r <= occ_r;
        end
      endcase
    end
  end

  assign head = head_r;
  assign occ  = occ_r;

endmodule

// File: rtl/fifo_burst_drain.sv
// Pops words from a synchronous FIFO and re-emits them as fixed-length
// valid/ready bursts; an idle timeout closes a partial burst.
module fifo_burst_drain
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_re,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
);

  localparam int BCW = cnt_width(BURST_LEN - 1);
  localparam int ICW = cnt_width(TIMEOUT);
  localparam logic [BCW-1:0] BEAT_MAX = BCW'(BURST_LEN - 1);
  localparam logic [ICW-1:0] IDLE_MAX = ICW'(TIMEOUT - 1);
  localparam logic [ICW-1:0] IDLE_TOP = ICW'(TIMEOUT);

  logic                  inflight_r;
  logic [BCW-1:0]        beat_cnt_r;
  logic [ICW-1:0]        idle_cnt_r;
  logic                  flush_r;

  logic [DATA_WIDTH-1:0] head_s;
  logic [1:0]            occ_s;
  logic                  has_word_s;
  logic                  at_end_s;
  logic                  re_s;
  logic                  valid_s;
  logic                  last_s;
  logic                  xfer_s;
  logic                  idle_inc_s;

  drain_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_r),
    .push_data (fifo_rdata),
    .pop       (xfer_s),
    .head      (head_s),
    .occ       (occ_s)
  );

  // Read issue, hold-back presentation and idle detection, all from registers.
  always_comb begin
    has_word_s = (occ_s != 2'd0);
    at_end_s   = (beat_cnt_r == BEAT_MAX);
    // One read outstanding at most, so the lagging empty flag is always seen.
    re_s       = !rst && !fifo_empty && !inflight_r && (occ_s != 2'd2);
    // A lone word is held back unless it must end the burst.
    valid_s    = !rst && has_word_s && ((occ_s == 2'd2) || at_end_s || flush_r);
    last_s     = valid_s && (at_end_s || (flush_r && (occ_s == 2'd1) && !inflight_r));
    xfer_s     = valid_s && m_ready;
    idle_inc_s = (occ_s == 2'd1) && !inflight_r && fifo_empty && !valid_s;
  end

  // Read tracking, beat position, idle timer and flush request.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_r <= 1'b0;
      beat_cnt_r <= {BCW{1'b0}};
      idle_cnt_r <= {ICW{1'b0}};
      flush_r    <= 1'b0;
    end else begin
      inflight_r <= re_s;

      if (xfer_s) begin
        beat_cnt_r <= last_s ? {BCW{1'b0}} : beat_cnt_r + BCW'(1'b1);
      end else begin
        beat_cnt_r <= beat_cnt_r;
      end

      if (xfer_s && last_s) begin
        flush_r <= 1'b0;
      end else if (idle_inc_s && (idle_cnt_r == IDLE_MAX)) begin
        flush_r <= 1'b1;
      end else begin
        flush_r <= flush_r;
      end

      if (re_s || xfer_s) begin
        idle_cnt_r <= {ICW{1'b0}};
      end else if (idle_inc_s && (idle_cnt_r != IDLE_TOP)) begin
        idle_cnt_r <= idle_cnt_r + ICW'(1'b1);
      end else begin
        idle_cnt_r <= idle_cnt_r;
      end
    end
  end

  assign fifo_re = re_s;
  assign m_valid = valid_s;
  assign m_last  = last_s;
  assign m_data  = (!rst && has_word_s) ? head_s : {DATA_WIDTH{1'b0}};
  assign busy    = !rst && ((beat_cnt_r != {BCW{1'b0}}) || has_word_s || inflight_r);

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Directed bench for fifo_burst_drain with a behavioural FIFO read port
// (registered read data and empty flag) driven from the stimulus process.
module tb_fifo_burst_drain;

  localparam int DW = 8;
  localparam int BL = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_rdata = 8'h00;
  logic          fifo_re;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] sent[$];
  logic [DW-1:0] out_d[$];
  logic          out_l[$];

  logic          last_re = 1'b0;
  logic          prev_valid = 1'b0;
  logic          prev_xfer = 1'b0;
  logic          prev_rst = 1'b1;
  logic [DW-1:0] prev_data = 8'h00;
  logic          rand_ready = 1'b0;

  always #5 clk = ~clk;

  fifo_burst_drain #(
    .DATA_WIDTH(DW),
    .BURST_LEN (BL),
    .TIMEOUT   (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_re    (fifo_re),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, then update the FIFO model just after posedge.
  task automatic tick();
    logic re_v;
    logic xf_v;
    @(negedge clk);
    re_v = fifo_re;
    xf_v = m_valid & m_ready;
    if (re_v) chk("re_spacing", {31'd0, last_re}, 32'd0);
    if (!rst && !prev_rst && prev_valid && !prev_xfer) begin
      chk("valid_hold", {31'd0, m_valid}, 32'd1);
      chk("data_hold", {24'd0, m_data}, {24'd0, prev_data});
    end
    if (xf_v) begin
      out_d.push_back(m_data);
      out_l.push_back(m_last);
    end
    last_re    = re_v;
    prev_valid = m_valid;
    prev_xfer  = xf_v;
    prev_data  = m_data;
    prev_rst   = rst;
    @(posedge clk);
    #1;
    if (re_v && fq.size() > 0) fifo_rdata = fq.pop_front();
    fifo_empty = (fq.size() == 0);
    if (rand_ready) m_ready = ($urandom_range(1, 0) == 1);
  endtask

  task automatic drain(input string tag, input int n);
    int k;
    k = 0;
    while (out_d.size() < n && k < 3000) begin
      tick();
      k++;
    end
    chk(tag, 32'(out_d.size()), 32'(n));
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 500) begin
      tick();
      k++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic clear_log();
    out_d.delete();
    out_l.delete();
  endtask

  initial begin
    int cnt;
    int pos;
    int k;

    // 1: reset with an empty FIFO
    rst = 1'b1;
    repeat (5) tick();
    chk("rst_re", {31'd0, fifo_re}, 32'd0);
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_last", {31'd0, m_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_data", {24'd0, m_data}, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_valid", {31'd0, m_valid}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // 2: one full burst of four
    m_ready = 1'b1;
    clear_log();
    for (int i = 0; i < 4; i++) fq.push_back(8'h11 + 8'(i));
    drain("t2_count", 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_data", {24'd0, out_d[i]}, 32'h11 + 32'(i));
      chk("t2_last", {31'd0, out_l[i]}, (i == 3) ? 32'd1 : 32'd0);
    end
    wait_idle("t2_idle");

    // 3: two words, the second closed by the idle timeout
    clear_log();
    fq.push_back(8'hA1);
    fq.push_back(8'hA2);
    drain("t3_first", 1);
    chk("t3_a1_data", {24'd0, out_d[0]}, 32'hA1);
    chk("t3_a1_last", {31'd0, out_l[0]}, 32'd0);
    cnt = 0;
    while (!m_valid && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("t3_timeout_cycles", 32'(cnt), 32'd16);
    chk("t3_a2_data", {24'd0, m_data}, 32'hA2);
    chk("t3_a2_last", {31'd0, m_last}, 32'd1);
    drain("t3_second", 2);
    chk("t3_a2_out", {24'd0, out_d[1]}, 32'hA2);
    chk("t3_a2_out_last", {31'd0, out_l[1]}, 32'd1);
    wait_idle("t3_idle");

    // 4: sink stall with eight words queued
    clear_log();
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) fq.push_back(8'h01 + 8'(i));
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i >= 8) begin
        chk("t4_stall_re", {31'd0, fifo_re}, 32'd0);
        chk("t4_stall_valid", {31'd0, m_valid}, 32'd1);
        chk("t4_stall_data", {24'd0, m_data}, 32'h01);
      end
    end
    m_ready = 1'b1;
    drain("t4_count", 8);
    for (int i = 0; i < 8; i++) begin
      chk("t4_data", {24'd0, out_d[i]}, 32'h01 + 32'(i));
      chk("t4_last", {31'd0, out_l[i]}, (i == 3 || i == 7) ? 32'd1 : 32'd0);
    end
    wait_idle("t4_idle");

    // 5: random fill and random sink readiness over 1000 words
    clear_log();
    sent.delete();
    rand_ready = 1'b1;
    k = 0;
    while (out_d.size() < 1000 && k < 30000) begin
      if (sent.size() < 1000 && fq.size() < 8 && $urandom_range(3, 0) != 0) begin
        sent.push_back(8'($urandom_range(255, 0)));
        fq.push_back(sent[sent.size() - 1]);
      end
      tick();
      k++;
    end
    chk("t5_count", 32'(out_d.size()), 32'd1000);
    wait_idle("t5_idle");
    rand_ready = 1'b0;
    m_ready = 1'b1;
    pos = 0;
    for (int i = 0; i < out_d.size() && i < sent.size(); i++) begin
      chk("t5_data", {24'd0, out_d[i]}, {24'd0, sent[i]});
      if (pos == BL - 1) chk("t5_burst_end", {31'd0, out_l[i]}, 32'd1);
      pos = out_l[i] ? 0 : pos + 1;
    end
    chk("t5_closed", 32'(pos), 32'd0);

    // 6: reset in the middle of a burst with a read in flight
    clear_log();
    for (int i = 0; i < 4; i++) fq.push_back(8'h31 + 8'(i));
    k = 0;
    while (!(out_d.size() == 2 && last_re) && k < 200) begin
      tick();
      k++;
    end
    chk("t6_reach", 32'(out_d.size()), 32'd2);
    chk("t6_inflight", {31'd0, last_re}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fq.delete();
    fifo_empty = 1'b1;
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_valid", {31'd0, m_valid}, 32'd0);
    chk("t6_data", {24'd0, m_data}, 32'd0);
    chk("t6_re", {31'd0, fifo_re}, 32'd0);
    clear_log();
    for (int i = 0; i < 4; i++) fq.push_back(8'h41 + 8'(i));
    drain("t6_count", 4);
    for (int i = 0; i < 4; i++) begin
      chk("t6_out_data", {24'd0, out_d[i]}, 32'h41 + 32'(i));
      chk("t6_out_last", {31'd0, out_l[i]}, (i == 3) ? 32'd1 : 32'd0);
    end
    wait_idle("t6_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
